// File: rtl/tl_boot_rom.sv
`default_nettype none
// ============================================================================
// Module   : tl_boot_rom
// Purpose  : TileLink-UL responder that serves the fixed boot-stub image from
//            a read-only array of 64-bit words. Get requests are answered with
//            AccessAckData, including multi-beat bursts. Writes and illegal
//            requests are answered with denied responses.
// Ports    : clk, rst          - clock, asynchronous active-high reset
//            a_*               - A channel (request) from the bus master
//            d_*               - D channel (response) back to the master
// Revision : 1.0 - initial release
// ============================================================================
module tl_boot_rom #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       SIZE_W    = 3,
  parameter int unsigned       SOURCE_W  = 8,
  parameter int unsigned       DEPTH     = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h1000,
  parameter int unsigned       MAX_SIZE  = 6
) (
  input  logic                clk,
  input  logic                rst,
  // A channel
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [2:0]          a_opcode,
  input  logic [SIZE_W-1:0]   a_size,
  input  logic [SOURCE_W-1:0] a_source,
  input  logic [ADDR_W-1:0]   a_address,
  // D channel
  output logic                d_valid,
  input  logic                d_ready,
  output logic [2:0]          d_opcode,
  output logic [2:0]          d_param,
  output logic [SIZE_W-1:0]   d_size,
  output logic [SOURCE_W-1:0] d_source,
  output logic                d_denied,
  output logic                d_corrupt,
  output logic [63:0]         d_data
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Wide enough to hold the beat count of the largest encodable a_size.
  localparam int unsigned CNT_W = 1 << SIZE_W;

  localparam logic [2:0] C_OP_PUT_FULL        = 3'd0;
  localparam logic [2:0] C_OP_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] C_OP_GET             = 3'd4;
  localparam logic [2:0] C_OP_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] C_OP_ACCESS_ACK_DATA = 3'd1;

  localparam logic [ADDR_W-1:0] C_WINDOW_BYTES = ADDR_W'(DEPTH * 8);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RESP = 1'b1;

  // Boot-stub image; words beyond the image read as zero.
  function automatic logic [63:0] rom_word(input int unsigned idx);
    case (idx)
      0:       rom_word = 64'h000015b7f1402573;
      1:       rom_word = 64'hb303638d1005859b;
      2:       rom_word = 64'h029b00638e33ff83;
      3:       rom_word = 64'h931601f292930010;
      4:       rom_word = 64'h000e338313611e61;
      5:       rom_word = 64'hfe62cae300733023;
      6:       rom_word = 64'h0000000000008282;
      default: rom_word = 64'h0000000000000000;
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [0:0]          state_q,     state_d;
  logic [CNT_W-1:0]    beat_q,      beat_d;
  logic [CNT_W-1:0]    last_q,      last_d;      // index of final beat
  logic [IDX_W-1:0]    idx0_q,      idx0_d;
  logic                d_valid_q,   d_valid_d;
  logic [2:0]          d_opcode_q,  d_opcode_d;
  logic [SIZE_W-1:0]   d_size_q,    d_size_d;
  logic [SOURCE_W-1:0] d_source_q,  d_source_d;
  logic                d_denied_q,  d_denied_d;
  logic                d_corrupt_q, d_corrupt_d;
  logic [63:0]         d_data_q,    d_data_d;

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0] w_offset;
  logic              w_in_window;
  logic              w_misaligned;
  logic              w_too_big;
  logic              w_is_get;
  logic              w_is_put;
  logic              w_overrun;
  logic              w_denied;
  logic [IDX_W-1:0]  w_idx0;
  logic [CNT_W-1:0]  w_last;
  logic [2:0]        w_resp_op;

  always_comb begin
    // An address below the base wraps to a huge offset, so one unsigned
    // compare covers both ends of the window.
    w_offset     = a_address - BASE_ADDR;
    w_in_window  = w_offset < C_WINDOW_BYTES;
    w_misaligned = (a_address & ((ADDR_W'(1) << a_size) - ADDR_W'(1))) != '0;
    w_too_big    = 32'(a_size) > MAX_SIZE;
    w_is_get     = a_opcode == C_OP_GET;
    w_is_put     = (a_opcode == C_OP_PUT_FULL) || (a_opcode == C_OP_PUT_PARTIAL);
    w_idx0       = w_offset[IDX_W+2:3];

    // Only Gets larger than one word are bursts; everything else is one beat.
    if (w_is_get && (a_size > SIZE_W'(3))) begin
      w_last = (CNT_W'(1) << (a_size - SIZE_W'(3))) - CNT_W'(1);
    end else begin
      w_last = '0;
    end

    // A burst running past the last word is denied rather than wrapped.
    w_overrun = (32'(w_idx0) + 32'(w_last)) >= DEPTH;
    w_denied  = !w_in_window || w_misaligned || w_too_big || w_overrun || !w_is_get;
    w_resp_op = w_is_put ? C_OP_ACCESS_ACK : C_OP_ACCESS_ACK_DATA;
  end

  logic             w_a_fire;
  logic             w_d_fire;
  logic             w_last_beat;
  logic [IDX_W-1:0] w_next_idx;

  assign w_a_fire    = a_valid && a_ready;
  assign w_d_fire    = d_valid_q && d_ready;
  assign w_last_beat = beat_q == last_q;
  assign w_next_idx  = idx0_q + IDX_W'(beat_q + CNT_W'(1));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      last_q      <= '0;
      idx0_q      <= '0;
      d_valid_q   <= 1'b0;
      d_opcode_q  <= '0;
      d_size_q    <= '0;
      d_source_q  <= '0;
      d_denied_q  <= 1'b0;
      d_corrupt_q <= 1'b0;
      d_data_q    <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      last_q      <= last_d;
      idx0_q      <= idx0_d;
      d_valid_q   <= d_valid_d;
      d_opcode_q  <= d_opcode_d;
      d_size_q    <= d_size_d;
      d_source_q  <= d_source_d;
      d_denied_q  <= d_denied_d;
      d_corrupt_q <= d_corrupt_d;
      d_data_q    <= d_data_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_a_fire) state_d = S_RESP;
      S_RESP:  if (w_d_fire && w_last_beat) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Response datapath
  // --------------------------------------------------------------------------
  always_comb begin
    beat_d      = beat_q;
    last_d      = last_q;
    idx0_d      = idx0_q;
    d_valid_d   = d_valid_q;
    d_opcode_d  = d_opcode_q;
    d_size_d    = d_size_q;
    d_source_d  = d_source_q;
    d_denied_d  = d_denied_q;
    d_corrupt_d = d_corrupt_q;
    d_data_d    = d_data_q;

    if (w_a_fire) begin
      // The grant/deny decision is taken once here and held for every beat.
      beat_d      = '0;
      last_d      = w_last;
      idx0_d      = w_idx0;
      d_valid_d   = 1'b1;
      d_opcode_d  = w_resp_op;
      d_size_d    = a_size;
      d_source_d  = a_source;
      d_denied_d  = w_denied;
      d_corrupt_d = w_denied && (w_resp_op == C_OP_ACCESS_ACK_DATA);
      d_data_d    = w_denied ? 64'h0 : rom_word(32'(w_idx0));
    end else if (w_d_fire) begin
      if (w_last_beat) begin
        beat_d    = '0;
        d_valid_d = 1'b0;
      end else begin
        // Next word is loaded on the same edge so beats run back-to-back.
        beat_d   = beat_q + CNT_W'(1);
        d_data_d = d_denied_q ? 64'h0 : rom_word(32'(w_next_idx));
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    a_ready   = (state_q == S_IDLE) && !rst;
    d_valid   = d_valid_q;
    d_opcode  = d_opcode_q;
    d_param   = 3'd0;
    d_size    = d_size_q;
    d_source  = d_source_q;
    d_denied  = d_denied_q;
    d_corrupt = d_corrupt_q;
    d_data    = d_data_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_tl_boot_rom.sv
`default_nettype none
// ============================================================================
// Module   : tb_tl_boot_rom
// Purpose  : Self-checking bench for tl_boot_rom. Directed vector table,
//            reset-during-burst sequence and a random request stream, all
//            compared against a request-level model of the boot ROM.
// Ports    : none (top-level bench)
// Revision : 1.0 - initial release
// ============================================================================
module tb_tl_boot_rom;

  logic        clk;
  logic        rst;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_opcode;
  logic [2:0]  a_size;
  logic [7:0]  a_source;
  logic [31:0] a_address;
  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_opcode;
  logic [2:0]  d_param;
  logic [2:0]  d_size;
  logic [7:0]  d_source;
  logic        d_denied;
  logic        d_corrupt;
  logic [63:0] d_data;

  tl_boot_rom dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_opcode  (a_opcode),
    .a_size    (a_size),
    .a_source  (a_source),
    .a_address (a_address),
    .d_valid   (d_valid),
    .d_ready   (d_ready),
    .d_opcode  (d_opcode),
    .d_param   (d_param),
    .d_size    (d_size),
    .d_source  (d_source),
    .d_denied  (d_denied),
    .d_corrupt (d_corrupt),
    .d_data    (d_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] rom_img [8];

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  sz;
    logic [7:0]  src;
    logic [31:0] addr;
    int          stall_beat;
    int          stall_n;
    logic [2:0]  eop;
    logic        eden;
    int          nb;
    int          first;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Request-level model: window of DEPTH*8 bytes starting at 'h1000.
  function automatic void model(input logic [2:0] op, input logic [2:0] sz,
                                input logic [31:0] addr, output logic [2:0] eop,
                                output logic eden, output int nb, output int first);
    longint a    = {32'h0, addr};
    longint base = 64'h1000;
    eop   = (op == 3'd0 || op == 3'd1) ? 3'd0 : 3'd1;
    nb    = (op == 3'd4 && sz > 3'd3) ? (1 << (sz - 3)) : 1;
    first = (a >= base) ? int'((a - base) / 8) : -1;
    eden  = (op != 3'd4) || (sz > 3'd6) || ((a % (64'd1 << sz)) != 0) ||
            (first < 0) || (first + nb > 8);
  endfunction

  // Presents a request and waits (bounded) for the A handshake.
  task automatic issue(input logic [2:0] op, input logic [2:0] sz, input logic [7:0] src,
                       input logic [31:0] addr, output bit ok);
    int guard = 0;
    a_opcode  = op;
    a_size    = sz;
    a_source  = src;
    a_address = addr;
    a_valid   = 1'b1;
    while (!a_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    ok = a_ready;
    if (!ok) begin
      chk("a_ready timeout", {63'h0, a_ready}, 64'h1);
      a_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
  endtask

  task automatic run_txn(input logic [2:0] op, input logic [2:0] sz, input logic [7:0] src,
                         input logic [31:0] addr, input logic [2:0] eop, input logic eden,
                         input int nb, input int first, input int stall_beat,
                         input int stall_n, input bit rnd);
    bit          ok;
    logic [63:0] exp_data;
    int          nst;
    issue(op, sz, src, addr, ok);
    if (!ok) return;
    // Keep a junk request pending; it must be ignored while responding.
    a_valid   = 1'b1;
    a_opcode  = 3'($urandom);
    a_address = $urandom;
    chk("d_valid latency", {63'h0, d_valid}, 64'h1);
    for (int k = 0; k < nb; k++) begin
      exp_data = eden ? 64'h0 : rom_img[first + k];
      chk("d_valid beat",  {63'h0, d_valid},   64'h1);
      chk("d_opcode",      {61'h0, d_opcode},  {61'h0, eop});
      chk("d_param",       {61'h0, d_param},   64'h0);
      chk("d_size",        {61'h0, d_size},    {61'h0, sz});
      chk("d_source",      {56'h0, d_source},  {56'h0, src});
      chk("d_denied",      {63'h0, d_denied},  {63'h0, eden});
      chk("d_corrupt",     {63'h0, d_corrupt}, {63'h0, eden && (eop == 3'd1)});
      chk("d_data",        d_data,             exp_data);
      chk("a_ready busy",  {63'h0, a_ready},   64'h0);
      nst = (k == stall_beat) ? stall_n : (rnd ? int'($urandom_range(0, 2)) : 0);
      for (int s = 0; s < nst; s++) begin
        d_ready = 1'b0;
        @(posedge clk); #1;
        chk("hold d_valid", {63'h0, d_valid}, 64'h1);
        chk("hold d_data",  d_data,           exp_data);
        chk("hold a_ready", {63'h0, a_ready}, 64'h0);
      end
      d_ready = 1'b1;
      @(posedge clk); #1;
    end
    a_valid = 1'b0;
    d_ready = 1'b0;
    chk("d_valid after last", {63'h0, d_valid}, 64'h0);
    chk("a_ready after last", {63'h0, a_ready}, 64'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          ok;
    logic [2:0]  r_op, r_sz, e_op;
    logic [7:0]  r_src;
    logic [31:0] r_addr;
    logic        e_den;
    int          e_nb, e_first;
    logic [2:0]  op_pool [7];

    rom_img[0] = 64'h000015b7f1402573;
    rom_img[1] = 64'hb303638d1005859b;
    rom_img[2] = 64'h029b00638e33ff83;
    rom_img[3] = 64'h931601f292930010;
    rom_img[4] = 64'h000e338313611e61;
    rom_img[5] = 64'hfe62cae300733023;
    rom_img[6] = 64'h0000000000008282;
    rom_img[7] = 64'h0000000000000000;

    //            op    sz    src    addr        stB stN eop   den   nb first
    vecs[0]  = '{3'd4, 3'd3, 8'h05, 32'h1000, -1, 0, 3'd1, 1'b0, 1,  0};
    vecs[1]  = '{3'd4, 3'd6, 8'h11, 32'h1000,  2, 3, 3'd1, 1'b0, 8,  0};
    vecs[2]  = '{3'd4, 3'd3, 8'h12, 32'h1040, -1, 0, 3'd1, 1'b1, 1,  0};
    vecs[3]  = '{3'd4, 3'd5, 8'h13, 32'h1030, -1, 0, 3'd1, 1'b1, 4,  0};
    vecs[4]  = '{3'd0, 3'd3, 8'h14, 32'h1008, -1, 0, 3'd0, 1'b1, 1,  0};
    vecs[5]  = '{3'd4, 3'd3, 8'h15, 32'h1004, -1, 0, 3'd1, 1'b1, 1,  0};
    vecs[6]  = '{3'd4, 3'd3, 8'h16, 32'h1018,  0, 2, 3'd1, 1'b0, 1,  3};
    vecs[7]  = '{3'd4, 3'd5, 8'h17, 32'h1020,  1, 1, 3'd1, 1'b0, 4,  4};
    vecs[8]  = '{3'd4, 3'd2, 8'h18, 32'h100c, -1, 0, 3'd1, 1'b0, 1,  1};
    vecs[9]  = '{3'd4, 3'd7, 8'h19, 32'h1000, -1, 0, 3'd1, 1'b1, 16, 0};
    vecs[10] = '{3'd2, 3'd3, 8'h1a, 32'h1000, -1, 0, 3'd1, 1'b1, 1,  0};
    vecs[11] = '{3'd1, 3'd6, 8'h1b, 32'h1000, -1, 0, 3'd0, 1'b1, 1,  0};
    vecs[12] = '{3'd4, 3'd3, 8'h1c, 32'h0ff8, -1, 0, 3'd1, 1'b1, 1,  0};
    vecs[13] = '{3'd4, 3'd3, 8'h1d, 32'h1038, -1, 0, 3'd1, 1'b0, 1,  7};
    vecs[14] = '{3'd4, 3'd4, 8'h1e, 32'h1010, -1, 0, 3'd1, 1'b0, 2,  2};

    op_pool = '{3'd4, 3'd4, 3'd4, 3'd4, 3'd0, 3'd1, 3'd2};

    // Reset state
    rst       = 1'b1;
    a_valid   = 1'b0;
    a_opcode  = 3'd0;
    a_size    = 3'd0;
    a_source  = 8'd0;
    a_address = 32'd0;
    d_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset a_ready",   {63'h0, a_ready},   64'h0);
    chk("reset d_valid",   {63'h0, d_valid},   64'h0);
    chk("reset d_data",    d_data,             64'h0);
    chk("reset d_denied",  {63'h0, d_denied},  64'h0);
    chk("reset d_corrupt", {63'h0, d_corrupt}, 64'h0);
    chk("reset d_opcode",  {61'h0, d_opcode},  64'h0);
    chk("reset d_size",    {61'h0, d_size},    64'h0);
    chk("reset d_source",  {56'h0, d_source},  64'h0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("a_ready after reset", {63'h0, a_ready}, 64'h1);

    // Directed vector table
    for (int i = 0; i < 15; i++) begin
      run_txn(vecs[i].op, vecs[i].sz, vecs[i].src, vecs[i].addr, vecs[i].eop,
              vecs[i].eden, vecs[i].nb, vecs[i].first, vecs[i].stall_beat,
              vecs[i].stall_n, 1'b0);
    end

    // Reset asserted while beat 3 of an 8-beat burst is on the bus
    issue(3'd4, 3'd6, 8'h33, 32'h1000, ok);
    a_valid = 1'b0;
    d_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("burst beat 3 data", d_data, rom_img[3]);
    rst = 1'b1;
    #1;
    chk("rst mid-burst d_valid", {63'h0, d_valid}, 64'h0);
    chk("rst mid-burst d_data",  d_data,           64'h0);
    chk("rst mid-burst a_ready", {63'h0, a_ready}, 64'h0);
    d_ready = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("a_ready after mid-burst rst", {63'h0, a_ready}, 64'h1);
    chk("d_valid after mid-burst rst", {63'h0, d_valid}, 64'h0);
    run_txn(3'd4, 3'd3, 8'h09, 32'h1018, 3'd1, 1'b0, 1, 3, -1, 0, 1'b0);

    // Random request stream with random back-pressure
    for (int t = 0; t < 40; t++) begin
      r_op  = op_pool[$urandom_range(0, 6)];
      r_sz  = 3'($urandom_range(0, 7));
      r_src = 8'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        r_addr = 32'h1000 + ((32'($urandom_range(0, 7)) * 32'd8) & ~((32'd1 << r_sz) - 32'd1));
      end else begin
        r_addr = 32'h0ff0 + 32'($urandom_range(0, 23)) * 32'd4;
        if ($urandom_range(0, 3) == 0) r_addr = r_addr + 32'($urandom_range(1, 3));
      end
      model(r_op, r_sz, r_addr, e_op, e_den, e_nb, e_first);
      run_txn(r_op, r_sz, r_src, r_addr, e_op, e_den, e_nb, e_first, -1, 0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
